// File: rtl/exec_monitor_pkg.sv
`default_nettype none
// ============================================================================
// exec_monitor_pkg -- shared state, halt-cause and NOP encodings. Rev 1.0
// ============================================================================
package exec_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [1:0]  CAUSE_NONE     = 2'd0;
    localparam logic [1:0]  CAUSE_NOP      = 2'd1;
    localparam logic [1:0]  CAUSE_MISALIGN = 2'd2;
    localparam logic [1:0]  CAUSE_TIMEOUT  = 2'd3;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// trace_fifo -- synchronous first-word fall-through FIFO. Rev 1.0
// ============================================================================
module trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB separates full from empty once the pointers wrap.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/exec_monitor.sv
`default_nettype none
// ============================================================================
// exec_monitor -- core run/halt detection, cycle counting and trace capture. Rev 1.0
// ============================================================================
module exec_monitor
    import exec_monitor_pkg::*;
#(
    parameter int NOP_LIMIT   = 6,
    parameter int CYCLE_LIMIT = 10000000,
    parameter int CNT_W       = 32,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic [31:0]      pc_if,
    input  logic [31:0]      pc_id,
    input  logic [31:0]      ir_id,
    input  logic             ir_valid,
    output logic             trc_valid,
    input  logic             trc_ready,
    output logic [31:0]      trc_pc,
    output logic [31:0]      trc_ir,
    output logic             halt,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [15:0]      drop_cnt,
    output logic             drain_done
);

    localparam int               NOP_W       = $clog2(NOP_LIMIT + 1);
    localparam logic [NOP_W-1:0] C_NOP_MAX   = NOP_W'(NOP_LIMIT);
    localparam logic [NOP_W-1:0] C_NOP_LAST  = NOP_W'(NOP_LIMIT - 1);
    localparam logic [CNT_W-1:0] C_CYC_LAST  = CNT_W'(CYCLE_LIMIT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [NOP_W-1:0] r_nop_cnt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [15:0]      r_drop_cnt;
    logic             r_halt;
    logic [1:0]       r_cause;

    logic             w_is_nop;
    logic             w_misalign;
    logic             w_nop_halt;
    logic             w_timeout;
    logic             w_halt_any;
    logic [1:0]       w_cause;
    logic             w_push_req;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_drop;
    logic [63:0]      w_fifo_dout;
    logic             w_unused_pc;

    assign w_unused_pc = &{1'b0, pc_if[31:2]};

    assign w_is_nop   = (ir_id == NOP_INSTR);
    assign w_misalign = (pc_if[1:0] != 2'b00);
    assign w_nop_halt = ir_valid && w_is_nop && (r_nop_cnt == C_NOP_LAST);
    assign w_timeout  = (r_cycle_cnt == C_CYC_LAST);
    assign w_halt_any = (r_state == RUN) && (w_misalign || w_nop_halt || w_timeout);

    always_comb begin
        w_cause = CAUSE_NONE;
        if (w_misalign)      w_cause = CAUSE_MISALIGN;
        else if (w_nop_halt) w_cause = CAUSE_NOP;
        else if (w_timeout)  w_cause = CAUSE_TIMEOUT;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (run_en) w_state_next = RUN;
            RUN: begin
                if (w_halt_any)   w_state_next = HALTED;
                else if (!run_en) w_state_next = IDLE;
            end
            HALTED:  w_state_next = HALTED;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    // Counters and the sticky halt record only move while the core runs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_nop_cnt   <= '0;
            r_cycle_cnt <= '0;
            r_drop_cnt  <= '0;
            r_halt      <= 1'b0;
            r_cause     <= CAUSE_NONE;
        end else begin
            if (r_state == RUN) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                if (ir_valid) begin
                    if (!w_is_nop)                 r_nop_cnt <= '0;
                    else if (r_nop_cnt != C_NOP_MAX) r_nop_cnt <= r_nop_cnt + 1'b1;
                end
            end
            if (w_halt_any) begin
                r_halt  <= 1'b1;
                r_cause <= w_cause;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign w_push_req = (r_state == RUN) && ir_valid;
    assign w_drop     = w_push_req && w_fifo_full && !(trc_valid && trc_ready);

    trace_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_trace_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push_req),
        .din   ({pc_id, ir_id}),
        .full  (w_fifo_full),
        .pop   (trc_ready),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty)
    );

    assign trc_valid  = !w_fifo_empty;
    assign trc_pc     = w_fifo_dout[63:32];
    assign trc_ir     = w_fifo_dout[31:0];
    assign halt       = r_halt;
    assign halt_cause = r_cause;
    assign cycle_cnt  = r_cycle_cnt;
    assign drop_cnt   = r_drop_cnt;
    assign drain_done = (r_state == HALTED) && w_fifo_empty;

endmodule
`default_nettype wire

// File: doc/exec_monitor.md
Name: exec_monitor

Overview:
Synthesizable run/halt monitor that sits directly downstream of the PROCESSOR core. It consumes the core's fetch PC and decode-stage instruction, detects the halt conditions (consecutive NOPs, misaligned PC, cycle limit), and counts cycles. It also buffers per-instruction trace records (pc, ir) in a small FIFO for a valid/ready consumer such as a UART dumper or LED driver. This makes halt detection and trace capture available on the FPGA build, not only in simulation.

Parameters:
NOP_LIMIT, 6, consecutive valid NOPs (ir==0) that cause a halt
CYCLE_LIMIT, 10000000, RUN cycles after which a timeout halt occurs
CNT_W, 32, width of cycle_cnt
FIFO_DEPTH, 8, trace FIFO entries; power of two, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
run_en  in  1  core released from reset / running
pc_if  in  32  fetch-stage PC
pc_id  in  32  PC of instruction in decode
ir_id  in  32  instruction in decode
ir_valid  in  1  decode stage advanced this cycle (ir_id is new)
trc_valid  out  1  trace record available
trc_ready  in  1  consumer accepts record
trc_pc  out  32  head record PC
trc_ir  out  32  head record instruction
halt  out  1  sticky halt flag
halt_cause  out  2  0 none, 1 NOP run, 2 misaligned PC, 3 timeout
cycle_cnt  out  CNT_W  RUN cycles elapsed
drop_cnt  out  16  trace records dropped (saturating)
drain_done  out  1  halt && FIFO empty

Behaviour:
- Reset: clk is the clock; rst is synchronous and active-low. With rst==0 at a posedge, the next state is IDLE. All of the following are cleared to 0: halt, halt_cause, cycle_cnt, drop_cnt, nop counter and FIFO pointers. trc_valid and drain_done then read 0. A reset mid-operation (any state, FIFO non-empty) clears everything the same way; FIFO contents are discarded.
- FSM states IDLE, RUN, HALTED:
  - IDLE -> RUN when run_en==1.
  - RUN -> HALTED when any halt condition is detected.
  - HALTED is sticky until reset; run_en is ignored.
  - RUN -> IDLE when run_en falls; counters hold their values.
- cycle_cnt increments by 1 every clk in RUN and freezes in IDLE and HALTED.
- NOP counter, RUN only:
  - ir_valid && ir_id==0 -> increment, saturating at NOP_LIMIT.
  - ir_valid && ir_id!=0 -> clear.
  - !ir_valid -> hold.
- Halt conditions, evaluated combinationally in RUN:
  - NOP: a valid NOP arrives with counter==NOP_LIMIT-1.
  - MISALIGN: pc_if[1:0]!=2'b00.
  - TIMEOUT: cycle_cnt==CYCLE_LIMIT-1, so the incremented value equals CYCLE_LIMIT.
- Halt latency: halt and halt_cause are registered and assert on the posedge that samples the condition. They are visible 1 cycle after the condition inputs are presented.
- Simultaneous conditions: priority MISALIGN > NOP > TIMEOUT.
- Trace FIFO push: in RUN, each ir_valid pushes {pc_id, ir_id}, including the halting instruction. No pushes in IDLE or HALTED.
- FIFO full:
  - Push without a same-cycle pop is dropped; drop_cnt += 1, saturating at 0xFFFF.
  - Push with a same-cycle pop (trc_valid&&trc_ready) is accepted; no drop.
- FIFO read side:
  - First-word fall-through: trc_valid = !empty; trc_pc/trc_ir show the head entry combinationally from storage.
  - Pop on trc_valid&&trc_ready.
  - Records are stable while trc_valid && !trc_ready.
  - Draining continues in HALTED.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; the extra MSB distinguishes full from empty on wrap-around.
- drain_done = (state==HALTED) && empty, registered with the FIFO state.

Decomposition:
- Package exec_monitor_pkg holds:
  - state enum {IDLE, RUN, HALTED};
  - cause constants CAUSE_NONE=0, CAUSE_NOP=1, CAUSE_MISALIGN=2, CAUSE_TIMEOUT=3;
  - the NOP encoding 32'h0.
- One sub-module, trace_fifo: synchronous FWFT FIFO, parameterised width 64 and depth, with push/full and pop/empty.
- The FSM, counters and halt logic stay in exec_monitor.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with run_en=1 and random inputs -> halt=0, halt_cause=0, cycle_cnt=0, trc_valid=0, drop_cnt=0.
2. NOP run:
   - run_en=1, then six valid ir_id=0 -> halt=1 and cause=1 the cycle after the 6th.
   - 5 NOPs, one 0x24080001, 5 NOPs -> halt stays 0.
3. Misaligned PC: pc_if=0x00000402 -> halt=1, cause=2 next cycle. Present it together with the 6th NOP -> cause=2 (priority).
4. Timeout with CYCLE_LIMIT=20 and no NOPs -> halt at cycle_cnt==20, cause=3; cycle_cnt stays 20 for 10 more cycles.
5. Trace FIFO (FIFO_DEPTH=8):
   - trc_ready=0, 10 valid instructions -> 8 stored, drop_cnt=2.
   - Raise trc_ready -> 8 records in order, matching the pushed pc/ir.
   - Full FIFO with simultaneous push+pop -> no drop.
6. Reset mid-operation: halted with 5 records queued, assert rst=0 for one cycle -> trc_valid=0, halt=0, cycle_cnt=0, drain_done=0 next cycle. Then drain: after the last pop in HALTED, drain_done=1.
